// File: rtl/writeback_stage_if.sv
// ---------------------------------------------------------------------------
// writeback_stage_if
//
// Purpose: carries the memory-stage result bundle into the writeback stage.
// The MEM stage drives it through the master modport. The writeback stage
// samples it through the slave modport.
//
// Signals:
//   mem_write_enable       instruction in MEM writes a GPR
//   mem_write_address      destination GPR
//   mem_write_data         ALU result, used when the load type is none
//   mem_load_type          0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6/7 none
//   mem_address_low        effective address bits [1:0]
//   mem_load_data          raw aligned word from data memory
//   mem_hilo_write_enable  instruction writes HI and LO
//   mem_hi_data            new HI value
//   mem_lo_data            new LO value
// ---------------------------------------------------------------------------
interface writeback_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     mem_write_enable;
    logic [ADDRESS_WIDTH-1:0] mem_write_address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic [2:0]               mem_load_type;
    logic [1:0]               mem_address_low;
    logic [DATA_WIDTH-1:0]    mem_load_data;
    logic                     mem_hilo_write_enable;
    logic [DATA_WIDTH-1:0]    mem_hi_data;
    logic [DATA_WIDTH-1:0]    mem_lo_data;

    // MEM stage side: produces the bundle.
    modport master (
        output mem_write_enable,
        output mem_write_address,
        output mem_write_data,
        output mem_load_type,
        output mem_address_low,
        output mem_load_data,
        output mem_hilo_write_enable,
        output mem_hi_data,
        output mem_lo_data
    );

    // Writeback stage side: consumes the bundle.
    modport slave (
        input mem_write_enable,
        input mem_write_address,
        input mem_write_data,
        input mem_load_type,
        input mem_address_low,
        input mem_load_data,
        input mem_hilo_write_enable,
        input mem_hi_data,
        input mem_lo_data
    );
endinterface

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// Purpose: the MEM-to-WB pipeline register and load formatter of the 5-stage
// core. It captures the memory-stage result and formats load data. Loads are
// big-endian, so lane 0 is bits [31:24]. Byte and halfword loads are lane
// selected, then sign- or zero-extended. The register file write port is
// driven one cycle after the instruction leaves MEM. The stage also holds
// the architectural HI/LO pair.
//
// Optional feature: macro WRITEBACK_HILO_EN.
//   defined   - HI/LO registers are built. They are written on a capture
//               edge when mem_hilo_write_enable is set.
//   undefined - HI/LO storage is not built. hi and lo are constant 0, and
//               the hilo inputs are ignored.
//
// Ports:
//   clock          in   system clock; all state updates on posedge
//   reset          in   synchronous, active-low
//   stall          in   hold all stage state this cycle
//   flush          in   insert a bubble this cycle (wins over stall)
//   mem_bus        in   writeback_stage_if.slave, the MEM result bundle
//   write_enable   out  register file write enable
//   write_address  out  register file write address
//   write_data     out  register file write data
//   load_error     out  a misaligned load occupies WB this cycle
//   hi, lo         out  architectural HI / LO
//
// Every output comes straight from a register. There is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module writeback_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    writeback_stage_if.slave         mem_bus,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     load_error,
    output logic [DATA_WIDTH-1:0]    hi,
    output logic [DATA_WIDTH-1:0]    lo
);

    localparam logic [2:0] LOAD_NONE = 3'd0;
    localparam logic [2:0] LOAD_LB   = 3'd1;
    localparam logic [2:0] LOAD_LBU  = 3'd2;
    localparam logic [2:0] LOAD_LH   = 3'd3;
    localparam logic [2:0] LOAD_LHU  = 3'd4;
    localparam logic [2:0] LOAD_LW   = 3'd5;

    // -----------------------------------------------------------------------
    // Lane extraction (big-endian: lane 0 is the most significant byte)
    // -----------------------------------------------------------------------
    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = mem_bus.mem_load_data[DATA_WIDTH-1-8*gi -: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = mem_bus.mem_load_data[DATA_WIDTH-1-16*gi -: 16];
        end
    endgenerate

    assign byte_sel = byte_lane[mem_bus.mem_address_low];
    // For halfwords, address bit 1 picks the half. Bit 0 only matters for
    // misalignment detection.
    assign half_sel = half_lane[mem_bus.mem_address_low[1]];

    // -----------------------------------------------------------------------
    // Load formatting and misalignment detection
    // -----------------------------------------------------------------------
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] formatted_data;

    always_comb begin
        misaligned     = 1'b0;
        formatted_data = mem_bus.mem_write_data;
        case (mem_bus.mem_load_type)
            LOAD_LB: begin
                formatted_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            end
            LOAD_LBU: begin
                formatted_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            end
            LOAD_LH: begin
                misaligned     = mem_bus.mem_address_low[0];
                formatted_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            end
            LOAD_LHU: begin
                misaligned     = mem_bus.mem_address_low[0];
                formatted_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            end
            LOAD_LW: begin
                misaligned     = (mem_bus.mem_address_low != 2'd0);
                formatted_data = mem_bus.mem_load_data;
            end
            // LOAD_NONE and the unused encodings 6/7 pass the ALU result.
            default: begin
                misaligned     = 1'b0;
                formatted_data = mem_bus.mem_write_data;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state values for the GPR write port
    // -----------------------------------------------------------------------
    logic                     write_enable_next;
    logic [ADDRESS_WIDTH-1:0] write_address_next;
    logic [DATA_WIDTH-1:0]    write_data_next;
    logic                     load_error_next;

    // A misaligned load is squashed: it does not write and carries no data.
    // The destination address is still passed along so that it is visible
    // to whoever handles the load error.
    assign write_enable_next  = mem_bus.mem_write_enable & ~misaligned;
    assign write_address_next = mem_bus.mem_write_address;
    assign write_data_next    = misaligned ? '0 : formatted_data;
    assign load_error_next    = misaligned;

    // -----------------------------------------------------------------------
    // Pipeline register. Priority is reset > flush > stall > capture.
    // -----------------------------------------------------------------------
    logic                     write_enable_reg;
    logic [ADDRESS_WIDTH-1:0] write_address_reg;
    logic [DATA_WIDTH-1:0]    write_data_reg;
    logic                     load_error_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            write_enable_reg  <= 1'b0;
            write_address_reg <= '0;
            write_data_reg    <= '0;
            load_error_reg    <= 1'b0;
        end else if (flush) begin
            write_enable_reg  <= 1'b0;
            write_address_reg <= '0;
            write_data_reg    <= '0;
            load_error_reg    <= 1'b0;
        end else if (!stall) begin
            write_enable_reg  <= write_enable_next;
            write_address_reg <= write_address_next;
            write_data_reg    <= write_data_next;
            load_error_reg    <= load_error_next;
        end
    end

    assign write_enable  = write_enable_reg;
    assign write_address = write_address_reg;
    assign write_data    = write_data_reg;
    assign load_error    = load_error_reg;

    // -----------------------------------------------------------------------
    // Architectural HI/LO
    // -----------------------------------------------------------------------
`ifdef WRITEBACK_HILO_EN
    logic [DATA_WIDTH-1:0] hi_reg;
    logic [DATA_WIDTH-1:0] lo_reg;

    // Only a real capture edge commits HI/LO. A stalled or flushed
    // mult/div/mthi/mtlo leaves the old pair in place.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (!flush && !stall && mem_bus.mem_hilo_write_enable) begin
            hi_reg <= mem_bus.mem_hi_data;
            lo_reg <= mem_bus.mem_lo_data;
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;
`else
    // No storage is built for HI/LO. The hilo inputs are folded into a
    // sink so that they are visibly intentionally unused.
    logic unused_hilo;
    assign unused_hilo = ^{mem_bus.mem_hilo_write_enable,
                           mem_bus.mem_hi_data,
                           mem_bus.mem_lo_data};

    assign hi = '0;
    assign lo = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
//
// Self-checking bench for writeback_stage. It runs directed scenarios, then
// randomized traffic. All of it is compared against a behavioural model
// that applies the stage rules with plain arithmetic. HI/LO expectations
// follow WRITEBACK_HILO_EN.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        stall;
    logic        flush;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        load_error;
    logic [31:0] hi;
    logic [31:0] lo;

    writeback_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) mem_bus ();

    writeback_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .mem_bus       (mem_bus.slave),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .load_error    (load_error),
        .hi            (hi),
        .lo            (lo)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) checks_passed++;
        else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // ------------------------------------------------------------------
    // Reference model state: what each output should show after the edge
    // ------------------------------------------------------------------
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic        exp_le;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    // Formats a load from its rules: pick the lane by shifting, mask it,
    // and add the sign fill when the value is negative.
    task automatic model_format(input logic [2:0] lt, input logic [1:0] a,
                                input logic [31:0] ld, input logic [31:0] wd,
                                output logic mis, output logic [31:0] val);
        logic [31:0] part;
        mis = 1'b0;
        val = wd;
        if (lt == 3'd1 || lt == 3'd2) begin
            part = (ld >> (8 * (3 - int'(a)))) & 32'h0000_00FF;
            val  = part;
            if (lt == 3'd1 && part >= 32'd128) val = part + 32'hFFFF_FF00;
        end else if (lt == 3'd3 || lt == 3'd4) begin
            if (a % 2 == 1) mis = 1'b1;
            part = (ld >> ((a == 2'd0) ? 16 : 0)) & 32'h0000_FFFF;
            val  = part;
            if (lt == 3'd3 && part >= 32'd32768) val = part + 32'hFFFF_0000;
        end else if (lt == 3'd5) begin
            if (a != 2'd0) mis = 1'b1;
            val = ld;
        end
        if (mis) val = 32'd0;
    endtask

    // Updates the model for the upcoming edge, using the inputs now applied.
    task automatic model_step();
        logic        mis;
        logic [31:0] val;
        model_format(mem_bus.mem_load_type, mem_bus.mem_address_low,
                     mem_bus.mem_load_data, mem_bus.mem_write_data, mis, val);
        if (!reset) begin
            exp_we = 0; exp_wa = 0; exp_wd = 0; exp_le = 0; exp_hi = 0; exp_lo = 0;
        end else if (flush) begin
            exp_we = 0; exp_wa = 0; exp_wd = 0; exp_le = 0;
        end else if (!stall) begin
            exp_we = mem_bus.mem_write_enable && !mis;
            exp_wa = mem_bus.mem_write_address;
            exp_wd = val;
            exp_le = mis;
`ifdef WRITEBACK_HILO_EN
            if (mem_bus.mem_hilo_write_enable) begin
                exp_hi = mem_bus.mem_hi_data;
                exp_lo = mem_bus.mem_lo_data;
            end
`endif
        end
    endtask

    task automatic check_all(input string tag);
        check_value({tag, ".we"}, {31'd0, write_enable}, {31'd0, exp_we});
        check_value({tag, ".wa"}, {27'd0, write_address}, {27'd0, exp_wa});
        check_value({tag, ".wd"}, write_data, exp_wd);
        check_value({tag, ".le"}, {31'd0, load_error}, {31'd0, exp_le});
        check_value({tag, ".hi"}, hi, exp_hi);
        check_value({tag, ".lo"}, lo, exp_lo);
    endtask

    task automatic set_mem(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [2:0] lt, input logic [1:0] a, input logic [31:0] ld);
        mem_bus.mem_write_enable  = we;
        mem_bus.mem_write_address = wa;
        mem_bus.mem_write_data    = wd;
        mem_bus.mem_load_type     = lt;
        mem_bus.mem_address_low   = a;
        mem_bus.mem_load_data     = ld;
    endtask

    task automatic set_hilo(input logic hwe, input logic [31:0] h, input logic [31:0] l);
        mem_bus.mem_hilo_write_enable = hwe;
        mem_bus.mem_hi_data           = h;
        mem_bus.mem_lo_data           = l;
    endtask

    // One clock: model the edge, let it happen, then compare 1 time unit later.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
        $display("cycle %s: rst=%0b st=%0b fl=%0b we=%0b wa=%0d wd=%08h le=%0b hi=%08h lo=%08h",
                 tag, reset, stall, flush, write_enable, write_address, write_data,
                 load_error, hi, lo);
    endtask

    task automatic load_case(input string tag, input logic [2:0] lt, input logic [1:0] a,
                             input logic [31:0] ld, input logic [31:0] want_wd,
                             input logic want_we, input logic want_le);
        set_mem(1'b1, 5'd9, 32'h5555_AAAA, lt, a, ld);
        cycle(tag);
        check_value({tag, ".const_wd"}, write_data, want_wd);
        check_value({tag, ".const_we"}, {31'd0, write_enable}, {31'd0, want_we});
        check_value({tag, ".const_le"}, {31'd0, load_error}, {31'd0, want_le});
    endtask

    localparam logic [31:0] HILO_HI = `ifdef WRITEBACK_HILO_EN 32'hDEAD_0000 `else 32'd0 `endif;
    localparam logic [31:0] HILO_LO = `ifdef WRITEBACK_HILO_EN 32'h0000_BEEF `else 32'd0 `endif;

    initial begin
        exp_we = 0; exp_wa = 0; exp_wd = 0; exp_le = 0; exp_hi = 0; exp_lo = 0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_mem(1'b1, 5'd5, 32'h1234_5678, 3'd0, 2'd0, 32'd0);
        set_hilo(1'b0, 32'd0, 32'd0);
        #1;

        // Reset for two cycles, even with stall/flush noise on the second.
        cycle("reset0");
        stall = 1'b1; flush = 1'b1;
        cycle("reset1");
        check_value("reset.wd_zero", write_data, 32'd0);
        stall = 1'b0; flush = 1'b0; reset = 1'b1;

        // First capture after reset: one-cycle latency.
        cycle("first_write");
        check_value("first.we", {31'd0, write_enable}, 32'd1);
        check_value("first.wa", {27'd0, write_address}, 32'd5);
        check_value("first.wd", write_data, 32'h1234_5678);

        // Byte loads.
        load_case("lb_a0",  3'd1, 2'd0, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b1, 1'b0);
        load_case("lbu_a0", 3'd2, 2'd0, 32'h80FF_7F01, 32'h0000_0080, 1'b1, 1'b0);
        load_case("lb_a2",  3'd1, 2'd2, 32'h80FF_7F01, 32'h0000_007F, 1'b1, 1'b0);
        load_case("lb_a3",  3'd1, 2'd3, 32'h80FF_7F01, 32'h0000_0001, 1'b1, 1'b0);
        load_case("lbu_a1", 3'd2, 2'd1, 32'h80FF_7F01, 32'h0000_00FF, 1'b1, 1'b0);
        // Halfword, word and misaligned.
        load_case("lh_a2",  3'd3, 2'd2, 32'h1234_F00D, 32'hFFFF_F00D, 1'b1, 1'b0);
        load_case("lhu_a0", 3'd4, 2'd0, 32'h1234_F00D, 32'h0000_1234, 1'b1, 1'b0);
        load_case("lw_a0",  3'd5, 2'd0, 32'h1234_F00D, 32'h1234_F00D, 1'b1, 1'b0);
        load_case("lw_a1",  3'd5, 2'd1, 32'h1234_F00D, 32'h0000_0000, 1'b0, 1'b1);
        load_case("lh_a3",  3'd3, 2'd3, 32'h1234_F00D, 32'h0000_0000, 1'b0, 1'b1);
        load_case("type7",  3'd7, 2'd1, 32'h1234_F00D, 32'h5555_AAAA, 1'b1, 1'b0);

        // Stall holds r7/0xA for three cycles while the inputs change.
        set_mem(1'b1, 5'd7, 32'h0000_000A, 3'd0, 2'd0, 32'd0);
        cycle("r7_capture");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_mem(1'($urandom), 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom);
            cycle("r7_stall");
            check_value("stall.wa", {27'd0, write_address}, 32'd7);
            check_value("stall.wd", write_data, 32'h0000_000A);
        end
        stall = 1'b0;

        // A misaligned load stays flagged while stalled, then flush clears it.
        set_mem(1'b1, 5'd3, 32'd0, 3'd5, 2'd2, 32'hCAFE_F00D);
        cycle("mis_capture");
        stall = 1'b1;
        set_mem(1'b1, 5'd4, 32'h1, 3'd0, 2'd0, 32'd0);
        cycle("mis_stall");
        check_value("mis_stall.le", {31'd0, load_error}, 32'd1);
        check_value("mis_stall.wa", {27'd0, write_address}, 32'd3);
        flush = 1'b1;
        cycle("stall_flush");
        check_value("flush.we", {31'd0, write_enable}, 32'd0);
        check_value("flush.le", {31'd0, load_error}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // HI/LO: a stalled write waits, the capture edge commits it, and a
        // flushed write is dropped. A GPR write rides in the same cycles.
        set_mem(1'b1, 5'd12, 32'h0BAD_0BAD, 3'd0, 2'd0, 32'd0);
        set_hilo(1'b1, 32'hDEAD_0000, 32'h0000_BEEF);
        stall = 1'b1;
        cycle("hilo_stall");
        check_value("hilo_stall.hi", hi, 32'd0);
        stall = 1'b0;
        cycle("hilo_capture");
        check_value("hilo_cap.hi", hi, HILO_HI);
        check_value("hilo_cap.lo", lo, HILO_LO);
        check_value("hilo_cap.wd", write_data, 32'h0BAD_0BAD);
        set_hilo(1'b1, 32'h1111_2222, 32'h3333_4444);
        flush = 1'b1;
        cycle("hilo_flush");
        check_value("hilo_flush.hi", hi, HILO_HI);
        check_value("hilo_flush.lo", lo, HILO_LO);
        flush = 1'b0;
        set_hilo(1'b0, 32'd0, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_mem(1'($urandom), 5'($urandom), $urandom, 3'($urandom_range(0, 7)),
                    2'($urandom), $urandom);
            set_hilo(1'($urandom), $urandom, $urandom);
            cycle("random");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Memory-to-writeback pipeline register and load formatter of the 5-stage core.
- Captures the memory-stage result, sign/zero-extends and lane-selects load data (big-endian), and drives the register file write port (write_enable/write_address/write_data) one cycle later.
- Also holds the architectural HI/LO pair written by mult/div/mthi/mtlo.
- Supports pipeline stall, flush and misaligned-load detection.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- ADDRESS_WIDTH, 5, register address width.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-low; clock clock.
- stall  in  1  hold all stage state this cycle.
- flush  in  1  insert bubble this cycle.
- mem_write_enable  in  1  instruction in MEM writes a GPR.
- mem_write_address  in  5  destination GPR.
- mem_write_data  in  32  ALU result; used when load type is none.
- mem_load_type  in  3  0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw; 6/7 treated as none.
- mem_address_low  in  2  effective address bits [1:0].
- mem_load_data  in  32  raw aligned word from data memory.
- mem_hilo_write_enable  in  1  instruction writes HI and LO.
- mem_hi_data  in  32  new HI value.
- mem_lo_data  in  32  new LO value.
- write_enable  out  1  to register file.
- write_address  out  5  to register file.
- write_data  out  32  to register file.
- load_error  out  1  misaligned load occupied WB this cycle.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (reset==0 at posedge): write_enable=0, write_address=0, write_data=0, load_error=0, hi=0, lo=0. Reset overrides stall and flush.
- Priority at each posedge with reset==1: flush > stall > capture.
- Flush: write_enable=0, write_address=0, write_data=0, load_error=0; hi/lo unchanged.
- Stall: every output register holds its value. A held write_enable=1 rewrites identical data, which is harmless.
- Capture: outputs are updated from the mem_* inputs, so latency MEM to register-file port is exactly 1 cycle.
- Load formatting is big-endian; lane 0 is bits [31:24].
  - lb/lbu: byte = mem_load_data[31-8*a -: 8], where a = mem_address_low. lb sign-extends, lbu zero-extends.
  - lh/lhu: a=0 selects [31:16]; a=2 selects [15:0]. lh sign-extends, lhu zero-extends.
  - lw: full word.
  - none: write_data = mem_write_data.
- Misaligned load:
  - Conditions: lh/lhu with a[0]=1, or lw with a!=0.
  - Result: write_enable=0, write_address captured as given, write_data=0, load_error=1 for the cycle(s) the instruction sits in WB. load_error is held on stall and cleared on flush.
- write_address==0 passes through unchanged; the register file discards it. No special-casing here.
- write_enable output = mem_write_enable AND NOT misaligned.
- HI/LO:
  - On a capture edge with mem_hilo_write_enable=1: hi<=mem_hi_data, lo<=mem_lo_data.
  - No update on stall, flush or reset-release cycle.
  - A GPR write and a HI/LO write may occur in the same cycle; both take effect.
- No combinational path from any input to any output.

Optional Feature:
- Macro WRITEBACK_HILO_EN.
- Defined: HI/LO registers exist as described.
- Undefined: HI/LO storage is not built. hi and lo are constant 0. mem_hilo_write_enable, mem_hi_data and mem_lo_data are ignored. GPR path is unchanged.

Test Plan:
- Reset then load: hold reset=0 for 2 cycles, then capture mem_write_enable=1, address=5, load_type=none, data=0x12345678 → all outputs 0 during reset; next cycle write_enable=1, write_address=5, write_data=0x12345678.
- Byte loads: mem_load_data=0x80FF7F01, lb at a=0 → 0xFFFFFF80; lbu at a=0 → 0x00000080; lb at a=2 → 0x0000007F; lb at a=3 → 0x00000001.
- Halfword and misaligned: lh at a=2 with data 0x1234F00D → 0xFFFFF00D; lhu at a=0 → 0x00001234; lw at a=1 → write_enable=0, load_error=1, write_data=0.
- Stall/flush: capture a write to r7 of 0xA, then stall=1 for 3 cycles while inputs change → outputs hold r7/0xA. Then assert stall=1 and flush=1 together → write_enable=0, load_error=0.
- HI/LO (macro defined): hilo write with hi=0xDEAD0000, lo=0x0000BEEF, stalled one cycle then captured → hi/lo update only on the capture edge. Flush on a following hilo write leaves the values unchanged.
- Macro undefined: the same hilo stimulus → hi=lo=0 throughout; GPR results are identical to the macro-defined run.
